// File: rtl/sram_1rw1r_param_clr_if.sv
// rtl/sram_1rw1r_param_clr_if.sv - port bundle for the 1RW+1R SRAM with clear engine
interface sram_1rw1r_param_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
);
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  clr_req;
    logic                  busy;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1, clr_req,
        input  dout0, dout1, busy
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1, clr_req,
        output dout0, dout1, busy
    );
endinterface

// File: rtl/sram_1rw1r_param_clr.sv
// rtl/sram_1rw1r_param_clr.sv - 1RW+1R SRAM with lane-masked writes, clear engine and write-first forwarding
module sram_1rw1r_param_clr #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    RAM_DEPTH   = 256,
    parameter int                    WMASK_WIDTH = 8,
    parameter int                    NUM_WMASKS  = DATA_WIDTH / WMASK_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input logic                   clk0,
    input logic                   rst_n,
    sram_1rw1r_param_clr_if.slave bus
);
    generate
        if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_lane_width
            $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
        end
        if (NUM_WMASKS != DATA_WIDTH / WMASK_WIDTH) begin : g_bad_lane_count
            $error("NUM_WMASKS must equal DATA_WIDTH/WMASK_WIDTH");
        end
        if (RAM_DEPTH > 2 ** ADDR_WIDTH || RAM_DEPTH < 1) begin : g_bad_depth
            $error("RAM_DEPTH must be in 1..2**ADDR_WIDTH");
        end
    endgenerate

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;

    logic                  in_range0;
    logic                  in_range1;
    logic                  wr0;
    logic                  rd0;
    logic                  rd1;
    logic                  collide;
    logic [DATA_WIDTH-1:0] lane_bits;
    logic [DATA_WIDTH-1:0] rd_word0;
    logic [DATA_WIDTH-1:0] rd_word1;
    logic [DATA_WIDTH-1:0] fwd_word1;

    // Port accesses are masked off for the whole sweep, so the engine owns the array
    assign in_range0 = {1'b0, bus.addr0} < DEPTH_X;
    assign in_range1 = {1'b0, bus.addr1} < DEPTH_X;
    assign wr0       = (state == IDLE) && !bus.csb0 && !bus.web0 && in_range0;
    assign rd0       = (state == IDLE) && !bus.csb0 && bus.web0;
    assign rd1       = (state == IDLE) && !bus.csb1;
    assign collide   = wr0 && in_range1 && (bus.addr0 == bus.addr1);

    always_comb begin
        lane_bits = '0;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            lane_bits[i*WMASK_WIDTH +: WMASK_WIDTH] = {WMASK_WIDTH{bus.wmask0[i]}};
        end
    end

    // Out-of-range reads return zero rather than aliasing onto a real word
    assign rd_word0  = in_range0 ? mem[bus.addr0] : '0;
    assign rd_word1  = in_range1 ? mem[bus.addr1] : '0;
    assign fwd_word1 = collide ? ((rd_word1 & ~lane_bits) | (bus.din0 & lane_bits)) : rd_word1;

    always_ff @(posedge clk0) begin
        if (state == CLEAR) begin
            mem[cnt] <= CLEAR_VALUE;
        end else if (wr0) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (bus.wmask0[i]) begin
                    mem[bus.addr0][i*WMASK_WIDTH +: WMASK_WIDTH] <= bus.din0[i*WMASK_WIDTH +: WMASK_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            cnt       <= '0;
            bus.busy  <= 1'b1;
            bus.dout0 <= '0;
            bus.dout1 <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                IDLE: begin
                    if (bus.clr_req) begin
                        state    <= CLEAR;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
            if (rd0) begin
                bus.dout0 <= rd_word0;
            end
            if (rd1) begin
                bus.dout1 <= fwd_word1;
            end
        end
    end
endmodule

// File: tb/tb_sram_1rw1r_param_clr.sv
// tb/tb_sram_1rw1r_param_clr.sv - self-checking bench for sram_1rw1r_param_clr
module tb_sram_1rw1r_param_clr;
    localparam int          DEPTH_A = 256;
    localparam int          DEPTH_B = 200;
    localparam logic [31:0] CLR_A   = 32'h0000_0000;
    localparam logic [31:0] CLR_B   = 32'hA5A5_0F0F;

    logic       clk0 = 1'b0;
    logic       rst_n = 1'b0;
    logic       csb0 = 1'b1;
    logic       web0 = 1'b1;
    logic [3:0] wmask0 = '0;
    logic [7:0] addr0 = '0;
    logic [31:0] din0 = '0;
    logic       csb1 = 1'b1;
    logic [7:0] addr1 = '0;
    logic       clr_req = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] mm [2][256];
    int          left [2];
    logic [31:0] e0 [2];
    logic [31:0] e1 [2];

    always #5 clk0 = ~clk0;

    sram_1rw1r_param_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4)) ifa ();
    sram_1rw1r_param_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4)) ifb ();

    assign ifa.csb0 = csb0;   assign ifb.csb0 = csb0;
    assign ifa.web0 = web0;   assign ifb.web0 = web0;
    assign ifa.wmask0 = wmask0; assign ifb.wmask0 = wmask0;
    assign ifa.addr0 = addr0; assign ifb.addr0 = addr0;
    assign ifa.din0 = din0;   assign ifb.din0 = din0;
    assign ifa.csb1 = csb1;   assign ifb.csb1 = csb1;
    assign ifa.addr1 = addr1; assign ifb.addr1 = addr1;
    assign ifa.clr_req = clr_req; assign ifb.clr_req = clr_req;

    sram_1rw1r_param_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(DEPTH_A),
                           .WMASK_WIDTH(8), .CLEAR_VALUE(CLR_A))
        dut_a (.clk0(clk0), .rst_n(rst_n), .bus(ifa));

    sram_1rw1r_param_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(DEPTH_B),
                           .WMASK_WIDTH(8), .CLEAR_VALUE(CLR_B))
        dut_b (.clk0(clk0), .rst_n(rst_n), .bus(ifb));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic int depth_of(input int k);
        return (k == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    function automatic logic [31:0] clr_of(input int k);
        return (k == 0) ? CLR_A : CLR_B;
    endfunction

    // A clear is modelled as an instant fill plus a busy window of DEPTH cycles
    task automatic start_clear(input int k);
        left[k] = depth_of(k);
        for (int i = 0; i < 256; i++) mm[k][i] = clr_of(k);
    endtask

    task automatic model_step();
        int          d;
        logic [31:0] bm;
        logic [31:0] w;
        for (int k = 0; k < 2; k++) begin
            d = depth_of(k);
            if (left[k] > 0) begin
                left[k]--;
            end else begin
                bm = '0;
                for (int i = 0; i < 4; i++) if (wmask0[i]) bm[i*8 +: 8] = 8'hFF;
                if (!csb1) begin
                    if (addr1 < d) begin
                        w = mm[k][addr1];
                        if (!csb0 && !web0 && addr0 == addr1) w = (w & ~bm) | (din0 & bm);
                        e1[k] = w;
                    end else begin
                        e1[k] = '0;
                    end
                end
                if (!csb0) begin
                    if (web0) e0[k] = (addr0 < d) ? mm[k][addr0] : 32'h0;
                    else if (addr0 < d) mm[k][addr0] = (mm[k][addr0] & ~bm) | (din0 & bm);
                end
                if (clr_req) start_clear(k);
            end
        end
    endtask

    task automatic compare_all();
        check("busy_a", 32'(ifa.busy), 32'(left[0] > 0));
        check("dout0_a", ifa.dout0, e0[0]);
        check("dout1_a", ifa.dout1, e1[0]);
        check("busy_b", 32'(ifb.busy), 32'(left[1] > 0));
        check("dout0_b", ifb.dout0, e0[1]);
        check("dout1_b", ifb.dout1, e1[1]);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk0);
        compare_all();
    endtask

    task automatic drive(input logic c0, input logic w0, input logic [3:0] m, input logic [7:0] a0,
                         input logic [31:0] d, input logic c1, input logic [7:0] a1, input logic cr);
        csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d;
        csb1 = c1; addr1 = a1; clr_req = cr;
        cycle();
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 1'b0);
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            start_clear(k);
            e0[k] = '0;
            e1[k] = '0;
        end
        compare_all();
        for (int i = 0; i < n; i++) begin
            @(negedge clk0);
            compare_all();
        end
        rst_n = 1'b1;
    endtask

    task automatic wait_clear(input string tag, input int already);
        int na = -1;
        int nb = -1;
        for (int n = already + 1; n <= already + 600; n++) begin
            idle();
            if (na < 0 && !ifa.busy) na = n;
            if (nb < 0 && !ifb.busy) nb = n;
            if (na >= 0 && nb >= 0) break;
        end
        check({tag, "_len_a"}, 32'(na), 32'(DEPTH_A));
        check({tag, "_len_b"}, 32'(nb), 32'(DEPTH_B));
    endtask

    initial begin
        @(negedge clk0);
        apply_reset(3);
        wait_clear("rst", 0);

        drive(1'b0, 1'b1, 4'h0, 8'h80, 32'h0, 1'b0, 8'h80, 1'b0);
        check("t1_rd0_a", ifa.dout0, 32'h0);
        check("t1_rd1_b", ifb.dout1, CLR_B);

        drive(1'b0, 1'b0, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 4'h5, 8'h10, 32'h11223344, 1'b1, 8'h00, 1'b0);
        check("t2_hold_a", ifa.dout0, 32'h0);
        drive(1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b1, 8'h00, 1'b0);
        check("t2_mask_a", ifa.dout0, 32'hDE22BE44);

        drive(1'b0, 1'b0, 4'hF, 8'h20, 32'hAAAAAAAA, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 4'h3, 8'h20, 32'h55555555, 1'b0, 8'h20, 1'b0);
        check("t3_fwd_a", ifa.dout1, 32'hAAAA5555);

        drive(1'b0, 1'b0, 4'hF, 8'h05, 32'h12345678, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 50; i++) drive(1'b0, 1'b0, 4'hF, 8'h05, 32'hFFFFFFFF, 1'b0, 8'h05, 1'b0);
        drive(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 1'b1);
        wait_clear("clr", 51);
        drive(1'b0, 1'b1, 4'h0, 8'h05, 32'h0, 1'b0, 8'h05, 1'b0);
        check("t4_clr_a", ifa.dout0, CLR_A);
        check("t4_clr_b", ifb.dout1, CLR_B);

        drive(1'b0, 1'b0, 4'hF, 8'h70, 32'h0BADF00D, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 4'hF, 8'hF0, 32'hFFFFFFFF, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 4'h0, 8'hF0, 32'h0, 1'b0, 8'hF0, 1'b0);
        check("t5_oor0_b", ifb.dout0, 32'h0);
        check("t5_oor1_b", ifb.dout1, 32'h0);
        check("t5_inr_a", ifa.dout0, 32'hFFFFFFFF);
        drive(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h70, 1'b0);
        check("t5_keep_b", ifb.dout1, 32'h0BADF00D);

        drive(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 99; i++) idle();
        apply_reset(2);
        check("t6_rst_d0", ifa.dout0, 32'h0);
        wait_clear("t6", 0);

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] a0;
            logic [7:0] a1;
            a0 = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'(8'h20 + $urandom_range(0, 3));
            a1 = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'(8'h20 + $urandom_range(0, 3));
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  a0, $urandom, 1'($urandom_range(0, 2) == 0), a1, 1'($urandom_range(0, 599) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
